// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed little-endian data memory behind a
// valid/ready request channel. It returns one response pulse per request,
// with a programmable read latency. Misaligned and out-of-range accesses
// are flagged on the response.
// Optional build macro DATA_MEM_TRACE_EN prints one trace line per response.
module data_mem_ctrl #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int unsigned BPW  = DATA_W / 8;
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned BSEL = $clog2(BPW);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [1:0]      CNT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;
   localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH);

   typedef logic [7:0] mem_t [DEPTH];

   function automatic mem_t mem_init();
      mem_t m;
      for (int unsigned i = 0; i < DEPTH; i++) m[i] = 8'(i);
      return m;
   endfunction

   // Power-up contents only; reset leaves the byte array untouched.
   mem_t mem = mem_init();

   logic [1:0]        state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              accept;
   logic              acc_err;
   logic              wr_en;
   logic [AW-1:0]     base;
   logic [ADDR_W:0]   span;
   logic [ADDR_W:0]   addr_end;
   logic [DATA_W-1:0] load_val;

   assign accept    = req_valid & req_ready;
   assign base      = req_addr[AW-1:0];
   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q & (state_q == RESP);

   // Range check is done one bit wider so the top of the address space cannot wrap.
   always_comb begin
      span     = req_size ? (ADDR_W + 1)'(BPW) : (ADDR_W + 1)'(1);
      addr_end = {1'b0, req_addr} + span;
      acc_err  = (addr_end > DEPTH_X) |
                 (req_size & (req_addr[BSEL-1:0] != '0));
      wr_en    = accept & req_write & ~acc_err & ~rst;
   end

   // Assemble the load result from the byte array as it stands at acceptance.
   always_comb begin
      load_val = '0;
      if (req_size) begin
         for (int unsigned k = 0; k < BPW; k++)
            load_val[8*k +: 8] = mem[base + AW'(k)];
      end else begin
         load_val = {{(DATA_W - 8){req_signed & mem[base][7]}}, mem[base]};
      end
   end

   // Request/wait/response sequencing and the held response data.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               err_d   = acc_err;
               rdata_d = (acc_err | req_write) ? '0 : load_val;
               if (!req_write && RD_LAT > 1) begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 2'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 2'd1;
         end
         RESP: begin
            state_d = IDLE;
            rdata_d = '0;
            err_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Store commit on the acceptance edge, little-endian byte order.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (req_size) begin
            for (int unsigned k = 0; k < BPW; k++)
               mem[base + AW'(k)] <= req_wdata[8*k +: 8];
         end else begin
            mem[base] <= req_wdata[7:0];
         end
      end
   end

`ifdef DATA_MEM_TRACE_EN
   logic              trc_write_q, trc_size_q;
   logic [ADDR_W-1:0] trc_addr_q;
   logic [DATA_W-1:0] trc_wdata_q;

   // Capture the request fields that the trace line reports.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trc_write_q <= 1'b0;
         trc_size_q  <= 1'b0;
         trc_addr_q  <= '0;
         trc_wdata_q <= '0;
      end else if (accept) begin
         trc_write_q <= req_write;
         trc_size_q  <= req_size;
         trc_addr_q  <= req_addr;
         trc_wdata_q <= req_size ? req_wdata : {{(DATA_W - 8){1'b0}}, req_wdata[7:0]};
      end
   end

   // One trace line per response cycle.
   always_ff @(posedge clk) begin
      if (state_q == RESP)
         $display("%0t %s%s%s addr=%h data=%h", $time,
                  trc_write_q ? "S" : "L", trc_size_q ? "W" : "B",
                  rsp_err ? " ERR" : "", trc_addr_q,
                  trc_write_q ? trc_wdata_q : rsp_rdata);
   end
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: a vector table on an RD_LAT=1
// instance, plus hand sequences on RD_LAT=3 and RD_LAT=4 instances.
module tb_data_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_write = 1'b0, req_size = 1'b0, req_signed = 1'b0;
   logic [15:0] req_addr = '0, req_wdata = '0;
   logic        valid [3];
   logic        ready [3];
   logic        rsp_v [3];
   logic [15:0] rdata [3];
   logic        err   [3];

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   data_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .RD_LAT(1)) u_lat1 (
      .clk(clk), .rst(rst), .req_valid(valid[0]), .req_ready(ready[0]),
      .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_v[0]),
      .rsp_rdata(rdata[0]), .rsp_err(err[0]));

   data_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .RD_LAT(3)) u_lat3 (
      .clk(clk), .rst(rst), .req_valid(valid[1]), .req_ready(ready[1]),
      .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_v[1]),
      .rsp_rdata(rdata[1]), .rsp_err(err[1]));

   data_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .RD_LAT(4)) u_lat4 (
      .clk(clk), .rst(rst), .req_valid(valid[2]), .req_ready(ready[2]),
      .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_v[2]),
      .rsp_rdata(rdata[2]), .rsp_err(err[2]));

   typedef struct {
      logic        w;
      logic        sz;
      logic        sg;
      logic [15:0] addr;
      logic [15:0] wd;
      logic [15:0] rd;
      logic        er;
   } vec_t;

   vec_t vt [18];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // One complete request on instance u; response latency and data are checked.
   task automatic xact(input int u, input logic w, input logic sz, input logic sg,
                       input logic [15:0] a, input logic [15:0] wd, input int lat,
                       input logic [15:0] erd, input logic eer, input string nm);
      int n;
      bit got;
      @(negedge clk);
      req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
      valid[u] = 1'b1;
      check({nm, "/ready"}, 32'(ready[u]), 32'd1);
      @(posedge clk);
      #1 valid[u] = 1'b0;
      n = 0;
      got = 1'b0;
      while (n < 8 && !got) begin
         @(negedge clk);
         n++;
         if (rsp_v[u]) got = 1'b1;
      end
      check({nm, "/lat"}, 32'(n), 32'(lat));
      check({nm, "/rdata"}, 32'(rdata[u]), 32'(erd));
      check({nm, "/err"}, 32'(err[u]), 32'(eer));
      @(negedge clk);
      check({nm, "/clear"}, {15'd0, rsp_v[u], rdata[u]}, 32'd0);
   endtask

   initial begin
      int pulses;
      for (int i = 0; i < 3; i++) valid[i] = 1'b0;

      //             w     sz    sg    addr      wdata     rdata     err
      vt[0]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1110, 1'b0};
      vt[1]  = '{1'b1, 1'b1, 1'b0, 16'h0020, 16'hBEEF, 16'h0000, 1'b0};
      vt[2]  = '{1'b0, 1'b0, 1'b1, 16'h0021, 16'h0000, 16'hFFBE, 1'b0};
      vt[3]  = '{1'b0, 1'b0, 1'b0, 16'h0021, 16'h0000, 16'h00BE, 1'b0};
      vt[4]  = '{1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'hBEEF, 1'b0};
      vt[5]  = '{1'b1, 1'b0, 1'b0, 16'h0031, 16'h1234, 16'h0000, 1'b0};
      vt[6]  = '{1'b0, 1'b0, 1'b0, 16'h0030, 16'h0000, 16'h0030, 1'b0};
      vt[7]  = '{1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h3430, 1'b0};
      vt[8]  = '{1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h0000, 1'b1};
      vt[9]  = '{1'b1, 1'b1, 1'b0, 16'h00FF, 16'hAAAA, 16'h0000, 1'b1};
      vt[10] = '{1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0000, 16'h00FF, 1'b0};
      vt[11] = '{1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1};
      vt[12] = '{1'b0, 1'b1, 1'b0, 16'h00FE, 16'h0000, 16'hFFFE, 1'b0};
      vt[13] = '{1'b1, 1'b0, 1'b0, 16'h00FF, 16'h0055, 16'h0000, 1'b0};
      vt[14] = '{1'b0, 1'b1, 1'b0, 16'h00FE, 16'h0000, 16'h55FE, 1'b0};
      vt[15] = '{1'b0, 1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h0000, 1'b1};
      vt[16] = '{1'b0, 1'b0, 1'b1, 16'h0081, 16'h0000, 16'hFF81, 1'b0};
      vt[17] = '{1'b0, 1'b0, 1'b1, 16'h007F, 16'h0000, 16'h007F, 1'b0};

      // Reset state.
      #1;
      check("rst/ready", 32'(ready[0]), 32'd1);
      check("rst/rsp_valid", 32'(rsp_v[0]), 32'd0);
      check("rst/rdata", 32'(rdata[0]), 32'd0);
      check("rst/err", 32'(err[0]), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Vector table on the RD_LAT=1 instance.
      for (int i = 0; i < 18; i++)
         xact(0, vt[i].w, vt[i].sz, vt[i].sg, vt[i].addr, vt[i].wd, 1,
              vt[i].rd, vt[i].er, $sformatf("v%0d", i));

      // RD_LAT=3: a store bypasses the wait, and a load takes 3 cycles.
      xact(1, 1'b1, 1'b1, 1'b0, 16'h0080, 16'h1357, 1, 16'h0000, 1'b0, "l3_sw");
      xact(1, 1'b0, 1'b1, 1'b0, 16'h0080, 16'h0000, 3, 16'h1357, 1'b0, "l3_lw");

      // RD_LAT=3: req_valid is held high; the second acceptance waits for IDLE.
      @(negedge clk);
      req_write = 1'b0; req_size = 1'b1; req_signed = 1'b0; req_addr = 16'h0040;
      valid[1] = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) req_addr = 16'h0050;
         check($sformatf("l3_hold_rdy%0d", k), 32'(ready[1]), 32'(k == 4));
         check($sformatf("l3_hold_rsp%0d", k), 32'(rsp_v[1]), 32'(k == 3 || k == 7));
         if (k == 3) check("l3_hold_data1", 32'(rdata[1]), 32'h4140);
         if (k == 7) check("l3_hold_data2", 32'(rdata[1]), 32'h5150);
      end
      valid[1] = 1'b0;
      @(negedge clk);

      // RD_LAT=4: a reset during WAIT drops the response; committed stores survive.
      xact(2, 1'b1, 1'b1, 1'b0, 16'h0070, 16'hCAFE, 1, 16'h0000, 1'b0, "l4_sw");
      @(negedge clk);
      req_write = 1'b0; req_size = 1'b1; req_addr = 16'h0060;
      valid[2] = 1'b1;
      @(posedge clk);
      #1 valid[2] = 1'b0;
      @(negedge clk);
      check("l4_wait_rdy", 32'(ready[2]), 32'd0);
      rst = 1'b1;
      #1;
      check("l4_rst_rdy", 32'(ready[2]), 32'd1);
      check("l4_rst_rsp", 32'(rsp_v[2]), 32'd0);
      check("l4_rst_rdata", 32'(rdata[2]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (8) begin
         @(negedge clk);
         if (rsp_v[2]) pulses++;
      end
      check("l4_dropped", 32'(pulses), 32'd0);
      xact(2, 1'b0, 1'b1, 1'b0, 16'h0070, 16'h0000, 4, 16'hCAFE, 1'b0, "l4_lw");
      xact(2, 1'b0, 1'b0, 1'b1, 16'h00F0, 16'h0000, 4, 16'hFFF0, 1'b0, "l4_lb");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Synchronous, parametrised successor to the processor data memory.
- Byte-addressed, little-endian storage with byte and word access, and sign- or zero-extended byte loads.
- Uses a valid/ready request channel and a response pulse with programmable read latency, and flags misaligned and out-of-range accesses.
- Sits between the MEM pipeline stage and the byte array and replaces the combinational data memory.

Parameters:
- DATA_W, 16, word width in bits; must be 16 or 32; BPW = DATA_W/8 bytes per word.
- ADDR_W, 16, request address width (byte address).
- DEPTH, 256, number of bytes stored; power of two, at most 2^ADDR_W.
- RD_LAT, 1, cycles from request acceptance to read response; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  1  0 = byte, 1 = word.
- req_signed  in  1  byte load only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data; a byte store uses req_wdata[7:0].
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  load result; 0 for stores and errors.
- rsp_err  out  1  with rsp_valid: access was misaligned or out of range.

Behaviour:
- Reset (asynchronous, active-high): FSM to IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Memory contents are not reset.
- Initial memory contents: mem[i] = i[7:0] for every byte i.
- Handshake: a request is accepted on a rising edge where req_valid && req_ready. All request fields are captured at acceptance. Exactly one rsp_valid pulse follows each accepted request. The response has no back-pressure.
- FSM states:
  - IDLE: req_ready=1. On acceptance, go to WAIT if the request is a load with RD_LAT>1; otherwise go to RESP.
  - WAIT: req_ready=0. The counter loads RD_LAT-2 on entry and decrements each cycle; go to RESP when it reaches 0.
  - RESP: rsp_valid=1 for exactly one cycle, req_ready=0, then return to IDLE.
- Timing: a load asserts rsp_valid RD_LAT cycles after the acceptance edge. A store asserts rsp_valid 1 cycle after acceptance. Throughput is one request per RD_LAT+1 cycles for loads and one per 2 cycles for stores.
- Error checks, evaluated at acceptance:
  - Word access with req_addr mod BPW != 0 is misaligned.
  - Access with req_addr + (req_size ? BPW : 1) > DEPTH is out of range.
  - On error, no memory write occurs and the response carries rsp_err=1 with rsp_rdata=0.
  - Byte accesses are never misaligned.
- Store (no error): memory is written on the acceptance edge. A word store writes mem[a+k] = wdata[8k+7:8k] for k=0..BPW-1. A byte store writes mem[a] = wdata[7:0].
- Load (no error): memory is sampled at the acceptance edge.
  - Word load: rsp_rdata = {mem[a+BPW-1] .. mem[a]}.
  - Byte load: rsp_rdata = sign- or zero-extension of mem[a], per req_signed.
  - rsp_rdata is held stable from the sample until the response cycle and returns to 0 after it.
- Store followed by a load to the same address: the load returns the new data, since the store completes before the next acceptance.
- Address arithmetic is done in ADDR_W+1 bits so the range check does not wrap at the top of the address space.
- req_valid is ignored while req_ready=0; no request is queued.
- rst asserted mid-operation: the pending response is dropped, no rsp_valid is produced, and any write already committed stays in memory.

Optional Feature:
- Macro DATA_MEM_TRACE_EN.
- When defined: on every response cycle the block issues $display with the simulation time, LW/LB/SW/SB (plus ERR when flagged), the address and the data in hex.
- When undefined: no display statements are compiled. Cycle behaviour is identical in both builds.

Test Plan:
- Reset then word load at 0x0010, RD_LAT=1, DATA_W=16 -> rsp_valid 1 cycle after acceptance, rsp_rdata=0x1110, rsp_err=0.
- Word store 0xBEEF at 0x0020, then byte load at 0x0021 with req_signed=1 -> 0xFFBE; same load with req_signed=0 -> 0x00BE; word load at 0x0020 -> 0xBEEF.
- Byte store 0x1234 at 0x0031 -> mem[0x31]=0x34 and mem[0x30] unchanged (0x30); word load at 0x0030 -> 0x3430.
- Word load at 0x0005 -> rsp_err=1, rsp_rdata=0. Word store at 0x00FF -> rsp_err=1 and mem[0xFF] still 0xFF. Byte load at 0x0100 -> rsp_err=1.
- RD_LAT=3: load accepted at cycle N -> req_ready low for cycles N+1..N+3, rsp_valid only at N+3; req_valid held high meanwhile is not accepted until cycle N+4.
- Assert rst in WAIT state (RD_LAT=4) -> no rsp_valid appears, req_ready=1 immediately, and a subsequent load returns correct data.
